// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register:
// state encodings, default widths and per-stage payload field widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CNT_W  = 16;

    localparam int OP_W     = 7;
    localparam int FUNCT7_W = 7;
    localparam int FUNCT3_W = 3;
    localparam int REG_W    = 5;
    localparam int WORD_W   = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used to observe output stalls.
// Holds at all-ones; cleared only by reset.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state;
    pipe_state_e       state_nx;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_nx;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_nx;
    logic              ready_q;

    assign in_ready = ready_q;

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (clear) begin
            state_nx = ST_EMPTY;
            main_nx  = BUBBLE;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nx = ST_FULL;
                        main_nx  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_nx = in_data;
                    end else if (out_xfer) begin
                        state_nx = ST_EMPTY;
                    end else if (in_xfer) begin
                        state_nx = ST_SKID;
                        skid_nx  = in_data;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_nx = ST_FULL;
                        main_nx  = skid_q;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // Ready is precomputed from the next state so it stays a pure flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            main_q  <= main_nx;
            skid_q  <= skid_nx;
            ready_q <= (state_nx != ST_SKID);
        end
    end
`else
    assign in_ready = !out_valid | out_ready;

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        if (clear) begin
            state_nx = ST_EMPTY;
            main_nx  = BUBBLE;
        end else if (in_xfer) begin
            state_nx = ST_FULL;
            main_nx  = in_data;
        end else if (out_xfer) begin
            state_nx = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
        end
    end
`endif

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed steps plus random traffic against
// a queue-based reference model of the stage.
module tb_pipe_stage_buf;

    localparam int              DW  = 32;
    localparam int              CW  = 4;
    localparam logic [DW-1:0]   BUB = 32'hDEAD_BEEF;
    localparam int              CMAX = (1 << CW) - 1;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] last;
    int            cnt;

    pipe_stage_buf #(
        .DATA_W(DW),
        .BUBBLE(BUB),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        if (SKID) return (q.size() < 2);
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " out_valid"}, DW'(out_valid), DW'(q.size() > 0));
        chk({tag, " out_data"}, out_data, (q.size() > 0) ? q[0] : last);
        chk({tag, " in_ready"}, DW'(in_ready), DW'(exp_ready()));
        chk({tag, " stall_cnt"}, DW'(stall_cnt), DW'(cnt));
    endtask

    task automatic model_reset();
        q.delete();
        last = BUB;
        cnt  = 0;
    endtask

    // Called just after a negedge: drive, check, advance model over posedge.
    task automatic step(input string tag, input bit iv, input logic [DW-1:0] id,
                        input bit ordy, input bit clr);
        bit in_x, out_x, stall;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clear     = clr;
        #1;
        check_outputs(tag);
        in_x  = iv && exp_ready();
        out_x = (q.size() > 0) && ordy;
        stall = (q.size() > 0) && !ordy;
        @(posedge clk);
        if (stall && cnt < CMAX) cnt++;
        if (clr) begin
            q.delete();
            last = BUB;
        end else begin
            if (out_x) last = q.pop_front();
            if (in_x) q.push_back(id);
        end
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        reset     = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;

        for (int k = 1; k <= 16; k++) step("stream", 1'b1, DW'(k), 1'b1, 1'b0);
        step("stream_tail", 1'b0, '0, 1'b1, 1'b0);
        step("stream_idle", 1'b0, '0, 1'b1, 1'b0);

        step("skid_a", 1'b1, 32'hA, 1'b0, 1'b0);
        step("skid_b", 1'b1, 32'hB, 1'b0, 1'b0);
        step("skid_hold", 1'b0, '0, 1'b0, 1'b0);
        step("drain_a", 1'b0, '0, 1'b1, 1'b0);
        step("drain_b", 1'b0, '0, 1'b1, 1'b0);
        step("drained", 1'b0, '0, 1'b1, 1'b0);

        step("pt_fill", 1'b1, 32'hC, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step("toggle", 1'b1, 32'hD0 + DW'(i), 1'(i % 2), 1'b0);
        step("toggle_drain0", 1'b0, '0, 1'b1, 1'b0);
        step("toggle_drain1", 1'b0, '0, 1'b1, 1'b0);
        step("toggle_drain2", 1'b0, '0, 1'b1, 1'b0);

        step("sat_fill", 1'b1, 32'h77, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat_hold", 1'b0, '0, 1'b0, 1'b0);
        chk("sat_value", DW'(stall_cnt), DW'(CMAX));
        step("sat_clear", 1'b0, '0, 1'b0, 1'b1);
        step("after_clear", 1'b0, '0, 1'b0, 1'b0);

        step("flush_w0", 1'b1, 32'h11, 1'b0, 1'b0);
        step("flush_w1", 1'b1, 32'h22, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h55, 1'b0, 1'b1);
        step("post_flush", 1'b0, '0, 1'b1, 1'b0);
        step("post_flush2", 1'b1, 32'h66, 1'b1, 1'b0);
        step("post_flush3", 1'b0, '0, 1'b1, 1'b0);

        step("mid_w0", 1'b1, 32'h123, 1'b0, 1'b0);
        step("mid_w1", 1'b1, 32'h456, 1'b0, 1'b0);
        async_reset("reset_mid");

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom % 4) != 0, DW'($urandom),
                 ($urandom % 3) != 0, ($urandom % 25) == 0);

        step("pre_reset", 1'b1, 32'h999, 1'b0, 1'b0);
        async_reset("reset_end");
        step("final", 1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
